// File: rtl/sha2_pkg.sv
// Shared constants and state encoding for the SHA-2 block unpacker.
package sha2_pkg;
  localparam int REG_W   = 64;
  localparam int REG_CNT = 8;
  localparam int DEC_W   = 3;
  localparam int BLK_W   = REG_W * REG_CNT;

  localparam logic [63:0] SHA2_PAD_WORD = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHK  = 2'd1,
    SEND = 2'd2
  } state_t;
endpackage

// File: rtl/sha2_pad_chk.sv
// Combinational padding/length checker for the final block of a message.
module sha2_pad_chk
  import sha2_pkg::*;
#(
  parameter int reg_w   = REG_W,
  parameter int reg_cnt = REG_CNT,
  parameter int dec_w   = DEC_W
) (
  input  logic [reg_cnt*reg_w-1:0] blk,
  input  logic [reg_w-1:0]         bit_cnt,
  output logic                     ok,
  output logic [dec_w-1:0]         p
);
  localparam int LW = $clog2(reg_w);

  logic [reg_w-1:0] len;
  logic [reg_w-1:0] word;

  always_comb begin
    len  = blk[(reg_cnt-1)*reg_w +: reg_w];
    p    = len[LW +: dec_w];
    ok   = (len[LW-1:0] == '0) && (p <= dec_w'(reg_cnt-2));
    word = '0;
    // Words below p are payload; p holds the pad marker; the rest up to the length word is zero fill.
    for (int i = 0; i < reg_cnt-1; i++) begin
      word = blk[i*reg_w +: reg_w];
      if (i == int'(p) && word != SHA2_PAD_WORD) ok = 1'b0;
      if (i > int'(p) && word != '0) ok = 1'b0;
    end
    if (len != bit_cnt + (reg_w'(p) << LW)) ok = 1'b0;
  end
endmodule

// File: rtl/sha2_blk_unpack.sv
// Unpacks 512-bit blocks into 64-bit packets, stripping and validating padding on the final block.
module sha2_blk_unpack
  import sha2_pkg::*;
#(
  parameter int reg_w   = REG_W,
  parameter int reg_cnt = REG_CNT,
  parameter int dec_w   = DEC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [reg_cnt*reg_w-1:0] blk,
  input  logic                     blk_vld,
  input  logic                     blk_last,
  output logic                     blk_rdy,
  output logic [reg_w-1:0]         pkt,
  output logic                     pkt_vld,
  input  logic                     pkt_rdy,
  output logic [dec_w-1:0]         idx,
  output logic                     msg_done,
  output logic                     len_err,
  output state_t                   fsm_state,
  output logic [reg_w-1:0]         bit_cnt
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // once raised, valid and its data hold until that edge, and ready never depends on valid.
  localparam int PW = dec_w + 1;

  state_t                   state_d;
  logic [reg_cnt*reg_w-1:0] shadow, shadow_d;
  logic                     last_q, last_d;
  logic [reg_w-1:0]         pkt_d, cnt_d;
  logic                     vld_d, done_d, err_d;
  logic [dec_w-1:0]         idx_d, idx_nxt;
  logic [PW-1:0]            p_q, p_d;
  logic                     chk_ok;
  logic [dec_w-1:0]         chk_p;

  sha2_pad_chk #(.reg_w(reg_w), .reg_cnt(reg_cnt), .dec_w(dec_w)) u_chk (
    .blk     (shadow),
    .bit_cnt (bit_cnt),
    .ok      (chk_ok),
    .p       (chk_p)
  );

  assign blk_rdy = (fsm_state == IDLE) && !rst;
  assign idx_nxt = idx + 1'b1;

  always_comb begin
    state_d  = fsm_state;
    shadow_d = shadow;
    last_d   = last_q;
    pkt_d    = pkt;
    vld_d    = pkt_vld;
    idx_d    = idx;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cnt_d    = bit_cnt;
    p_d      = p_q;
    case (fsm_state)
      IDLE: begin
        idx_d = '0;
        if (blk_vld) begin
          shadow_d = blk;
          last_d   = blk_last;
          state_d  = CHK;
        end
      end
      CHK: begin
        if (!last_q || (chk_ok && chk_p != '0)) begin
          p_d     = last_q ? {1'b0, chk_p} : PW'(reg_cnt);
          vld_d   = 1'b1;
          pkt_d   = shadow[0 +: reg_w];
          idx_d   = '0;
          state_d = SEND;
        end else begin
          done_d  = chk_ok;
          err_d   = !chk_ok;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      SEND: begin
        if (pkt_rdy) begin
          cnt_d = bit_cnt + reg_w'(reg_w);
          if ({1'b0, idx} == p_q - PW'(1)) begin
            vld_d   = 1'b0;
            idx_d   = '0;
            state_d = IDLE;
            if (last_q) begin
              done_d = 1'b1;
              cnt_d  = '0;
            end
          end else begin
            idx_d = idx_nxt;
            pkt_d = shadow[idx_nxt*reg_w +: reg_w];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_state <= IDLE;
      shadow    <= '0;
      last_q    <= 1'b0;
      pkt       <= '0;
      pkt_vld   <= 1'b0;
      idx       <= '0;
      msg_done  <= 1'b0;
      len_err   <= 1'b0;
      bit_cnt   <= '0;
      p_q       <= '0;
    end else begin
      fsm_state <= state_d;
      shadow    <= shadow_d;
      last_q    <= last_d;
      pkt       <= pkt_d;
      pkt_vld   <= vld_d;
      idx       <= idx_d;
      msg_done  <= done_d;
      len_err   <= err_d;
      bit_cnt   <= cnt_d;
      p_q       <= p_d;
    end
  end
endmodule

// File: tb/tb_sha2_blk_unpack.sv
// Randomized self-checking bench for sha2_blk_unpack against a message-level reference model.
module tb_sha2_blk_unpack;
  import sha2_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [511:0] blk;
  logic         blk_vld, blk_last, blk_rdy;
  logic [63:0]  pkt;
  logic         pkt_vld, pkt_rdy;
  logic [2:0]   idx;
  logic         msg_done, len_err;
  state_t       fsm_state;
  logic [63:0]  bit_cnt;

  int          total = 0;
  int          bad = 0;
  logic [63:0] model_bits;
  logic [63:0] exp_q[$];

  sha2_blk_unpack dut (
    .clk(clk), .rst(rst), .blk(blk), .blk_vld(blk_vld), .blk_last(blk_last),
    .blk_rdy(blk_rdy), .pkt(pkt), .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .idx(idx),
    .msg_done(msg_done), .len_err(len_err), .fsm_state(fsm_state), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] wd(input logic [511:0] b, input int i);
    return b[i*64 +: 64];
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: what a block should produce given the message bits already delivered.
  task automatic model_block(input logic [511:0] b, input logic last,
                             output bit e_done, output bit e_err);
    logic [63:0] len;
    int          p;
    bit          good;
    e_done = 0;
    e_err  = 0;
    if (!last) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(wd(b, i));
      model_bits = model_bits + 64'd512;
      return;
    end
    len  = wd(b, 7);
    good = (len % 64 == 0);
    p    = int'((len / 64) % 8);
    if (p > 6) good = 0;
    else begin
      if (wd(b, p) != SHA2_PAD_WORD) good = 0;
      for (int i = p + 1; i < 7; i++) if (wd(b, i) != 64'd0) good = 0;
    end
    if (len != model_bits + 64'(64 * p)) good = 0;
    if (good) begin
      for (int i = 0; i < p; i++) exp_q.push_back(wd(b, i));
      e_done = 1;
    end else e_err = 1;
    model_bits = '0;
  endtask

  // mode 0: pkt_rdy always 1 (latency checked); 1: pattern 1,0,0,1; 2: random
  task automatic run_block(input logic [511:0] b, input logic last, input int mode, input string nm);
    bit          e_done, e_err;
    int          n_exp, c, k, got_done, got_err;
    bit          prev_stall;
    logic [63:0] prev_pkt, exp_w;
    logic [2:0]  prev_idx;
    exp_q.delete();
    model_block(b, last, e_done, e_err);
    n_exp = exp_q.size();
    k = 0; got_done = 0; got_err = 0; prev_stall = 0; prev_pkt = '0; prev_idx = '0;
    @(negedge clk);
    blk = b; blk_vld = 1'b1; blk_last = last; pkt_rdy = 1'b0;
    #1;
    total++;
    if (blk_rdy !== 1'b1) begin bad++; $display("FAIL %s accept_rdy: got %b want 1", nm, blk_rdy); end
    @(negedge clk);
    blk_vld = 1'b0; blk = {8{rnd64()}}; blk_last = ~last;
    for (c = 0; c < 200; c++) begin
      case (mode)
        0:       pkt_rdy = 1'b1;
        1:       pkt_rdy = (c % 4 == 0) || (c % 4 == 3);
        default: pkt_rdy = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (msg_done) got_done++;
      if (len_err) got_err++;
      if (msg_done && len_err) begin
        total++; bad++; $display("FAIL %s pulse_excl: got done=1 err=1 want not both", nm);
      end
      if (prev_stall) begin
        total++;
        if (pkt_vld !== 1'b1 || pkt !== prev_pkt || idx !== prev_idx) begin
          bad++;
          $display("FAIL %s stall_hold: got vld=%b pkt=%h idx=%0d want vld=1 pkt=%h idx=%0d",
                   nm, pkt_vld, pkt, idx, prev_pkt, prev_idx);
        end
      end
      if (pkt_vld && pkt_rdy) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL %s extra_pkt: got %h want none", nm, pkt);
        end else begin
          exp_w = exp_q.pop_front();
          if (pkt !== exp_w) begin bad++; $display("FAIL %s pkt[%0d]: got %h want %h", nm, k, pkt, exp_w); end
        end
        total++;
        if (idx !== 3'(k)) begin bad++; $display("FAIL %s idx: got %0d want %0d", nm, idx, k); end
        if (mode == 0) begin
          total++;
          if (c != k + 1) begin bad++; $display("FAIL %s hs_cycle: got %0d want %0d", nm, c, k + 1); end
        end
        k++;
      end
      prev_stall = pkt_vld && !pkt_rdy;
      prev_pkt = pkt;
      prev_idx = idx;
      if (blk_rdy) break;
      @(negedge clk);
    end
    total++;
    if (!blk_rdy) begin bad++; $display("FAIL %s timeout: got blk_rdy=0 want 1 within 200 cycles", nm); end
    total++;
    if (got_done != int'(e_done)) begin bad++; $display("FAIL %s msg_done: got %0d want %0d", nm, got_done, e_done); end
    total++;
    if (got_err != int'(e_err)) begin bad++; $display("FAIL %s len_err: got %0d want %0d", nm, got_err, e_err); end
    total++;
    if (k != n_exp) begin bad++; $display("FAIL %s pkt_count: got %0d want %0d", nm, k, n_exp); end
    total++;
    if (bit_cnt !== model_bits) begin bad++; $display("FAIL %s bit_cnt: got %0d want %0d", nm, bit_cnt, model_bits); end
    if (mode == 0) begin
      total++;
      if (c != (n_exp > 0 ? n_exp + 1 : 1)) begin
        bad++; $display("FAIL %s end_cycle: got %0d want %0d", nm, c, (n_exp > 0 ? n_exp + 1 : 1));
      end
    end
    @(negedge clk);
    #1;
    total++;
    if (msg_done || len_err) begin bad++; $display("FAIL %s pulse_width: got done=%b err=%b want 0", nm, msg_done, len_err); end
  endtask

  task automatic test_reset();
    rst = 1'b1; blk = '0; blk_vld = 1'b0; blk_last = 1'b0; pkt_rdy = 1'b0;
    model_bits = '0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (blk_rdy !== 1'b0 || pkt_vld !== 1'b0 || pkt !== 64'd0 || idx !== 3'd0 ||
        msg_done !== 1'b0 || len_err !== 1'b0 || bit_cnt !== 64'd0 || fsm_state !== IDLE) begin
      bad++;
      $display("FAIL reset_vals: got rdy=%b vld=%b pkt=%h idx=%0d done=%b err=%b cnt=%0d st=%0d want all 0",
               blk_rdy, pkt_vld, pkt, idx, msg_done, len_err, bit_cnt, fsm_state);
    end
    rst = 1'b0;
    #1;
    total++;
    if (blk_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", blk_rdy); end
  endtask

  task automatic test_full_block();
    logic [511:0] b;
    for (int i = 0; i < 8; i++) b[i*64 +: 64] = 64'h0123_4567_89ab_cd00 + 64'(i);
    run_block(b, 1'b0, 0, "full_block");
  endtask

  task automatic test_final_one();
    logic [511:0] b;
    b = '0;
    b[0 +: 64]   = 64'hdead_beef_cafe_f00d;
    b[64 +: 64]  = SHA2_PAD_WORD;
    b[448 +: 64] = 64'd576;
    run_block(b, 1'b1, 0, "final_one");
  endtask

  task automatic test_final_empty();
    logic [511:0] b;
    b = '0;
    b[0 +: 64] = SHA2_PAD_WORD;
    run_block(b, 1'b1, 0, "final_empty");
  endtask

  task automatic test_len_err();
    logic [511:0] b;
    for (int i = 0; i < 8; i++) b[i*64 +: 64] = rnd64();
    run_block(b, 1'b0, 0, "pre_err");
    b = '0;
    b[128 +: 64] = 64'd1;
    b[448 +: 64] = 64'd128;
    run_block(b, 1'b1, 0, "len_err");
  endtask

  task automatic test_backpressure();
    logic [511:0] b;
    for (int i = 0; i < 8; i++) b[i*64 +: 64] = rnd64();
    run_block(b, 1'b0, 1, "backpressure");
  endtask

  task automatic test_reset_mid();
    logic [511:0] b;
    for (int i = 0; i < 8; i++) b[i*64 +: 64] = rnd64();
    @(negedge clk);
    blk = b; blk_vld = 1'b1; blk_last = 1'b0; pkt_rdy = 1'b1;
    @(negedge clk);
    blk_vld = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (pkt_vld !== 1'b1 || idx !== 3'd3 || pkt !== wd(b, 3)) begin
      bad++; $display("FAIL mid_pre: got vld=%b idx=%0d pkt=%h want 1 3 %h", pkt_vld, idx, pkt, wd(b, 3));
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (pkt_vld !== 1'b0 || pkt !== 64'd0 || idx !== 3'd0 || msg_done !== 1'b0 ||
        len_err !== 1'b0 || bit_cnt !== 64'd0 || blk_rdy !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got vld=%b pkt=%h idx=%0d done=%b err=%b cnt=%0d rdy=%b want all 0",
               pkt_vld, pkt, idx, msg_done, len_err, bit_cnt, blk_rdy);
    end
    rst = 1'b0;
    #1;
    total++;
    if (blk_rdy !== 1'b1) begin bad++; $display("FAIL mid_rdy: got %b want 1", blk_rdy); end
    model_bits = '0;
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [511:0] b;
    int           p, nfull, corrupt;
    for (int m = 0; m < 8; m++) begin
      nfull = $urandom_range(0, 2);
      for (int j = 0; j < nfull; j++) begin
        for (int i = 0; i < 8; i++) b[i*64 +: 64] = rnd64();
        run_block(b, 1'b0, 2, "rand_full");
      end
      p = $urandom_range(0, 6);
      b = '0;
      for (int i = 0; i < p; i++) b[i*64 +: 64] = rnd64();
      b[p*64 +: 64] = SHA2_PAD_WORD;
      b[448 +: 64]  = model_bits + 64'(64 * p);
      corrupt = $urandom_range(0, 4);
      case (corrupt)
        1: b[448 +: 64] = b[448 +: 64] ^ (64'd1 << $urandom_range(0, 5));
        2: b[448 +: 64] = b[448 +: 64] + 64'd512;
        3: b[p*64 +: 64] = b[p*64 +: 64] ^ 64'd1;
        4: b[384 +: 64] = (p < 6) ? 64'h10 : 64'd7;
        default: ;
      endcase
      run_block(b, 1'b1, $urandom_range(0, 2), "rand_final");
    end
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_final_one();
    test_final_empty();
    test_len_err();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sha2_blk_unpack.md
# sha2_blk_unpack

Block-to-packet unpacker for the SHA-2 message path: accepts 512-bit blocks and re-emits them as 64-bit packets, word 0 first, over a valid/ready stream. On the final block of a message it validates and strips the padding (0x8000_0000_0000_0000 pad word, zero fill, bit-length word), so only payload packets go out. It sits on the receive side of the packing input datapath and round-trips that block's output for loopback and verification.

## Interface
- `reg_w`, 64: packet/word width in bits.
- `reg_cnt`, 8: words per block.
- `dec_w`, 3: word index width (log2 `reg_cnt`).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `blk` in `reg_cnt*reg_w`: input block; word i = `blk[i*reg_w +: reg_w]`.
- `blk_vld` in 1: block offered.
- `blk_last` in 1: offered block is the final, padded block of a message.
- `blk_rdy` out 1: unpacker can accept a block.
- `pkt` out `reg_w`: payload packet.
- `pkt_vld` out 1: `pkt` valid.
- `pkt_rdy` in 1: downstream accepts `pkt`.
- `idx` out `dec_w`: index of the word currently on `pkt`.
- `msg_done` out 1: one-cycle pulse, final block processed with no error.
- `len_err` out 1: one-cycle pulse, final block failed the padding/length check.

## Operation
- States: IDLE, CHK, SEND.
- IDLE: `blk_rdy`=1. On `blk_vld & blk_rdy`, capture `blk` into a shadow register and `blk_last` into `last_q`, then go to CHK. `idx` is cleared.
- CHK (1 cycle), non-last block: payload count p=8, then go to SEND.
- CHK, last block: L = word 7 (message length in bits) and p = L[8:6]. The block is valid only if all of these hold: L[5:0]=0; p≤6; word p = 0x8000_0000_0000_0000; words p+1..6 = 0; and L = `bit_cnt` + 64·p.
  - Valid with p>0: go to SEND.
  - Valid with p=0: pulse `msg_done`, clear `bit_cnt`, go to IDLE.
  - Invalid: pulse `len_err`, clear `bit_cnt`, emit nothing, go to IDLE.
- SEND: `pkt_vld`=1 and `pkt` = shadow word `idx`.
  - On each `pkt_vld & pkt_rdy`: `idx`+1 and `bit_cnt`+64.
  - After the handshake with `idx`=p−1, go to IDLE.
  - If `last_q` is set, pulse `msg_done` and clear `bit_cnt`.
- `bit_cnt`: 64-bit running count of payload bits emitted for the current message. Addition wraps modulo 2^64.
- p=7 on a final block (padding spilling across blocks) is not supported and always gives `len_err`.
- `pkt` and `idx` stay stable while `pkt_vld & ~pkt_rdy`. `pkt_vld` never drops without a handshake.
- `blk` and `blk_last` are sampled only at the accept edge. Later changes have no effect.

## Timing
- Reset (`rst`=1 at an edge): state IDLE. `pkt`=0, `pkt_vld`=0, `idx`=0, `msg_done`=0, `len_err`=0, `bit_cnt`=0, shadow register=0. `blk_rdy` is forced to 0 while `rst`=1.
- Reset mid-operation: the current block is abandoned with no pulses, and `bit_cnt` is cleared.
- `blk_rdy` is 1 only in IDLE, so a new block can never arrive during CHK or SEND.
- Latency, with E0 as the accept edge:
  - CHK occupies the cycle after E0.
  - `pkt_vld` rises after E1.
  - With `pkt_rdy` held at 1, words 0..7 handshake at E2..E9.
  - `blk_rdy` is high again after E9.
  - Block throughput is therefore 10 cycles per 8-word block.
- `msg_done` and `len_err` are registered. They are high for exactly the one cycle after the deciding edge (the last payload handshake, or E1 in the CHK cases).
- `msg_done` and `len_err` are never high in the same cycle.
- All outputs are registered. There is no combinational path from `pkt_rdy` to `pkt_vld`.

## Structure
- Package `sha2_pkg`:
  - `SHA2_PAD_WORD` = 64'h8000_0000_0000_0000.
  - Block and word width constants.
  - State enum `{IDLE, CHK, SEND}`.
- One sub-module, `sha2_pad_chk`: a combinational checker. Inputs are the shadow block and `bit_cnt`; outputs are `ok` and `p`. The top level holds the FSM, shadow register, index counter and `bit_cnt`.

## Test plan
- Non-last block with words 0..7 = 0x…00..0x…07, `pkt_rdy`=1: 8 packets in order, `idx` 0..7 at E2..E9, no `msg_done`, `bit_cnt`=512.
- Follow with a final block: word0 = A, word1 = SHA2_PAD_WORD, words 2..6 = 0, word7 = 576. Expect one packet (A) and a `msg_done` pulse the cycle after its handshake.
- Final block only: word0 = SHA2_PAD_WORD, word7 = 0. Expect no packets and `msg_done` the cycle after CHK.
- Final block with word7 = 128 but word2 = 0x1: expect `len_err`, no packets, and `bit_cnt` reset to 0.
- Backpressure: toggle `pkt_rdy` 1,0,0,1… during a non-last block. `pkt`/`idx` stay frozen while stalled, all 8 words are delivered in order, and none are dropped or duplicated.
- Assert `rst` during SEND with `idx`=3: outputs return to reset values at the next edge, and `blk_rdy` is 1 in the first cycle after `rst` drops.
